// File: rtl/audio_source_mux_pkg.sv
// Shared definitions for the audio source mux: fader state encodings and default widths.
package audio_source_mux_pkg;

   localparam int SAMPLE_W_DEF  = 24;
   localparam int FADE_LOG2_DEF = 4;

   localparam logic [1:0] ST_MUTED    = 2'd0;
   localparam logic [1:0] ST_FADE_IN  = 2'd1;
   localparam logic [1:0] ST_RUN      = 2'd2;
   localparam logic [1:0] ST_FADE_OUT = 2'd3;

endpackage

// File: rtl/audio_source_mux_gain.sv
// Single-channel fader gain: (sample * gain) >>> FADE_LOG2, two's complement.
// Purely combinational, no latency; carries no flow control of its own.
module audio_gain
   import audio_source_mux_pkg::*;
#(
   parameter int SAMPLE_W  = SAMPLE_W_DEF,
   parameter int FADE_LOG2 = FADE_LOG2_DEF
) (
   input  logic [SAMPLE_W-1:0]  sample,
   input  logic [FADE_LOG2:0]   gain,
   output logic [SAMPLE_W-1:0]  scaled
);

   localparam int PW = SAMPLE_W + FADE_LOG2 + 1;

   logic signed [PW-1:0] sample_ext;
   logic signed [PW-1:0] gain_ext;
   logic signed [PW-1:0] product;

   // Gain is unsigned 0..2^FADE_LOG2, so zero-extend it before the signed multiply.
   assign sample_ext = {{(FADE_LOG2+1){sample[SAMPLE_W-1]}}, sample};
   assign gain_ext   = {{SAMPLE_W{1'b0}}, gain};
   assign product    = sample_ext * gain_ext;
   assign scaled     = SAMPLE_W'(product >>> FADE_LOG2);

endmodule

// File: rtl/audio_source_mux.sv
// Two-source stereo mux with frame-counted fade out/in on every source switch or mute.
// Latency 1 cycle accept-to-output; sources stall while the one-deep output is full and blocked.
module audio_source_mux
   import audio_source_mux_pkg::*;
#(
   parameter int SAMPLE_W  = SAMPLE_W_DEF,
   parameter int FADE_LOG2 = FADE_LOG2_DEF
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [2*SAMPLE_W-1:0] src0_sample,
   input  logic                  src0_valid,
   output logic                  src0_ready,
   input  logic [2*SAMPLE_W-1:0] src1_sample,
   input  logic                  src1_valid,
   output logic                  src1_ready,
   input  logic                  sel,
   input  logic                  mute,
   output logic [2*SAMPLE_W-1:0] audio_out,
   output logic                  audio_out_valid,
   input  logic                  audio_full,
   output logic                  cur_sel,
   output logic                  busy
);

   localparam int GW = FADE_LOG2 + 1;
   localparam logic [GW-1:0] G_FULL = GW'(1 << FADE_LOG2);
   localparam logic [GW-1:0] G_ONE  = GW'(1);

   logic [1:0]            state;
   logic [GW-1:0]         g;
   logic                  can_load;
   logic                  src_rdy;
   logic                  src_vld;
   logic                  accept;
   logic                  abort;
   logic [2*SAMPLE_W-1:0] src_dat;
   logic [2*SAMPLE_W-1:0] scaled_dat;

   assign can_load   = !audio_out_valid || !audio_full;
   assign src_rdy    = (state != ST_MUTED) && can_load;
   assign src0_ready = src_rdy && !cur_sel;
   assign src1_ready = src_rdy && cur_sel;
   assign src_vld    = cur_sel ? src1_valid  : src0_valid;
   assign src_dat    = cur_sel ? src1_sample : src0_sample;
   assign accept     = src_rdy && src_vld;
   assign abort      = (sel != cur_sel) || mute;
   assign busy       = (state != ST_RUN);

   audio_gain #(.SAMPLE_W(SAMPLE_W), .FADE_LOG2(FADE_LOG2)) u_gain_left (
      .sample (src_dat[2*SAMPLE_W-1:SAMPLE_W]),
      .gain   (g),
      .scaled (scaled_dat[2*SAMPLE_W-1:SAMPLE_W])
   );

   audio_gain #(.SAMPLE_W(SAMPLE_W), .FADE_LOG2(FADE_LOG2)) u_gain_right (
      .sample (src_dat[SAMPLE_W-1:0]),
      .gain   (g),
      .scaled (scaled_dat[SAMPLE_W-1:0])
   );

   // While muted, keep the sink fed with silence whenever the register can take a frame.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         audio_out       <= '0;
         audio_out_valid <= 1'b0;
      end else if (accept) begin
         audio_out       <= scaled_dat;
         audio_out_valid <= 1'b1;
      end else if ((state == ST_MUTED) && can_load) begin
         audio_out       <= '0;
         audio_out_valid <= 1'b1;
      end else if (audio_out_valid && !audio_full) begin
         audio_out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= ST_MUTED;
         g       <= '0;
         cur_sel <= 1'b0;
      end else begin
         case (state)
            ST_MUTED: begin
               g <= '0;
               if (!mute) begin
                  cur_sel <= sel;
                  state   <= ST_FADE_IN;
               end
            end
            ST_FADE_IN: begin
               if (accept) g <= g + G_ONE;
               if (abort) state <= ST_FADE_OUT;
               else if (accept && ((g + G_ONE) == G_FULL)) state <= ST_RUN;
            end
            ST_RUN: begin
               g <= G_FULL;
               if (abort) state <= ST_FADE_OUT;
            end
            ST_FADE_OUT: begin
               // Fade always completes; the g = 0 frame still passes as silence.
               if (g == '0) begin
                  cur_sel <= sel;
                  state   <= mute ? ST_MUTED : ST_FADE_IN;
               end else if (accept) begin
                  g <= g - G_ONE;
               end
            end
            default: state <= ST_MUTED;
         endcase
      end
   end

endmodule

// File: tb/tb_audio_source_mux.sv
// Scoreboard bench for audio_source_mux: expected frames queued on source accept, checked on sink transfer.
module tb_audio_source_mux;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [47:0] src0_sample, src1_sample, audio_out;
   logic        src0_valid, src0_ready, src1_valid, src1_ready;
   logic        sel, mute, audio_out_valid, audio_full, cur_sel, busy;

   int vectors = 0;
   int miscompares = 0;
   int seq1 = 1;
   logic [47:0] exp_q[$];
   logic        s_vld, s_xfer, s_r0, s_r1, s_busy, s_cur, s_a0, s_a1;
   logic [47:0] s_dat;

   audio_source_mux #(.SAMPLE_W(24), .FADE_LOG2(4)) dut (
      .clk(clk), .reset_n(reset_n),
      .src0_sample(src0_sample), .src0_valid(src0_valid), .src0_ready(src0_ready),
      .src1_sample(src1_sample), .src1_valid(src1_valid), .src1_ready(src1_ready),
      .sel(sel), .mute(mute),
      .audio_out(audio_out), .audio_out_valid(audio_out_valid), .audio_full(audio_full),
      .cur_sel(cur_sel), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [23:0] scale(input logic [23:0] s, input int g);
      int p;
      p = int'($signed(s)) * g;
      p = p >>> 4;
      return p[23:0];
   endfunction

   function automatic logic [47:0] scale_frame(input logic [47:0] f, input int g);
      return {scale(f[47:24], g), scale(f[23:0], g)};
   endfunction

   // Called at a falling edge: snapshot outputs 1 time unit later, then wait for the next falling edge.
   task automatic tick();
      #1;
      s_vld  = audio_out_valid;
      s_xfer = audio_out_valid && !audio_full;
      s_dat  = audio_out;
      s_r0   = src0_ready;
      s_r1   = src1_ready;
      s_busy = busy;
      s_cur  = cur_sel;
      s_a0   = src0_valid && src0_ready;
      s_a1   = src1_valid && src1_ready;
      @(negedge clk);
   endtask

   task automatic advance_src1();
      seq1++;
      src1_sample = {24'(seq1 * 4096), 24'h100000};
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      vectors++; if (audio_out !== 48'h0) begin miscompares++; $display("FAIL reset_audio_out: got %h want 0", audio_out); end
      vectors++; if (audio_out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", audio_out_valid); end
      vectors++; if (src0_ready !== 1'b0) begin miscompares++; $display("FAIL reset_src0_ready: got %b want 0", src0_ready); end
      vectors++; if (src1_ready !== 1'b0) begin miscompares++; $display("FAIL reset_src1_ready: got %b want 0", src1_ready); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL reset_busy: got %b want 1", busy); end
      vectors++; if (cur_sel !== 1'b0) begin miscompares++; $display("FAIL reset_cur_sel: got %b want 0", cur_sel); end
      @(negedge clk);
   endtask

   // Release reset with src0 at a constant 0x100000: zero frame, 16-step ramp, then steady full scale.
   task automatic test_fade_in();
      logic [47:0] e;
      int n0;
      n0 = 0;
      exp_q.delete();
      exp_q.push_back(48'h0);
      reset_n = 1'b1;
      for (int c = 0; c < 30; c++) begin
         tick();
         vectors++; if (s_busy !== (n0 < 16)) begin miscompares++; $display("FAIL fadein_busy: cycle %0d got %b want %b", c, s_busy, n0 < 16); end
         vectors++; if (s_r1 !== 1'b0) begin miscompares++; $display("FAIL fadein_src1_ready: cycle %0d got %b want 0", c, s_r1); end
         if (c >= 1) begin
            vectors++; if (s_vld !== 1'b1) begin miscompares++; $display("FAIL fadein_starved: cycle %0d valid %b want 1", c, s_vld); end
         end
         if (s_xfer) begin
            vectors++;
            if (exp_q.size() == 0) begin miscompares++; $display("FAIL fadein_extra: got %h, no frame expected", s_dat); end
            else begin
               e = exp_q.pop_front();
               if (s_dat !== e) begin miscompares++; $display("FAIL fadein_frame: got %h want %h", s_dat, e); end
               vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL fadein_latency: %0d frames in flight want 0", exp_q.size()); end
            end
         end
         if (s_a0) begin
            exp_q.push_back(scale_frame(src0_sample, (n0 < 16) ? n0 : 16));
            n0++;
         end
      end
   endtask

   // RUN on src0, switch to src1: src0 fades to silence, then src1 ramps in.
   task automatic test_switch();
      logic [47:0] e;
      int k0, k1;
      k0 = 0; k1 = 0;
      sel = 1'b1;
      for (int c = 0; c < 70; c++) begin
         src1_valid = ($urandom_range(0, 3) != 0);
         tick();
         vectors++; if (s_r0 && s_r1) begin miscompares++; $display("FAIL switch_overlap: src0_ready %b src1_ready %b", s_r0, s_r1); end
         if (s_xfer) begin
            vectors++;
            if (exp_q.size() == 0) begin miscompares++; $display("FAIL switch_extra: got %h, no frame expected", s_dat); end
            else begin
               e = exp_q.pop_front();
               if (s_dat !== e) begin miscompares++; $display("FAIL switch_frame: got %h want %h", s_dat, e); end
            end
         end
         if (s_a0) begin
            vectors++; if (k0 > 17) begin miscompares++; $display("FAIL switch_src0_late: accept %0d want at most 18", k0 + 1); end
            exp_q.push_back(scale_frame(src0_sample, (k0 == 0) ? 16 : ((k0 <= 17) ? 17 - k0 : 0)));
            k0++;
         end
         if (s_a1) begin
            exp_q.push_back(scale_frame(src1_sample, (k1 < 16) ? k1 : 16));
            k1++;
            advance_src1();
         end
      end
      vectors++; if (k0 != 18) begin miscompares++; $display("FAIL switch_src0_count: got %0d want 18", k0); end
      vectors++; if (s_cur !== 1'b1) begin miscompares++; $display("FAIL switch_cur_sel: got %b want 1", s_cur); end
      vectors++; if (s_busy !== 1'b0) begin miscompares++; $display("FAIL switch_busy: got %b want 0", s_busy); end
   endtask

   // Fade back to src0 with the sink blocked for 50 cycles mid-fade; src1 frames carry sequence numbers.
   task automatic test_stall();
      logic [47:0] e, held;
      int k0, k1;
      k0 = 0; k1 = 0;
      held = '0;
      sel = 1'b0;
      for (int c = 0; c < 110; c++) begin
         audio_full = (c >= 10 && c < 60);
         src1_valid = (c == 0 || (c >= 9 && c < 60)) ? 1'b1 : ($urandom_range(0, 3) != 0);
         tick();
         vectors++; if (s_r0 && s_r1) begin miscompares++; $display("FAIL stall_overlap: src0_ready %b src1_ready %b", s_r0, s_r1); end
         if (audio_full) begin
            if (c == 10) held = s_dat;
            else begin
               vectors++; if (s_dat !== held) begin miscompares++; $display("FAIL stall_hold: got %h want %h", s_dat, held); end
            end
            vectors++; if (s_r0 || s_r1 || !s_vld) begin miscompares++; $display("FAIL stall_ready: rdy0 %b rdy1 %b valid %b want 0 0 1", s_r0, s_r1, s_vld); end
         end
         if (s_xfer) begin
            vectors++;
            if (exp_q.size() == 0) begin miscompares++; $display("FAIL stall_extra: got %h, no frame expected", s_dat); end
            else begin
               e = exp_q.pop_front();
               if (s_dat !== e) begin miscompares++; $display("FAIL stall_frame: got %h want %h", s_dat, e); end
            end
         end
         if (s_a1) begin
            exp_q.push_back(scale_frame(src1_sample, (k1 == 0) ? 16 : ((k1 <= 17) ? 17 - k1 : 0)));
            k1++;
            advance_src1();
         end
         if (s_a0) begin
            exp_q.push_back(scale_frame(src0_sample, (k0 < 16) ? k0 : 16));
            k0++;
         end
      end
      audio_full = 1'b0;
      vectors++; if (s_cur !== 1'b0 || s_busy !== 1'b0) begin miscompares++; $display("FAIL stall_end: cur_sel %b busy %b want 0 0", s_cur, s_busy); end
   endtask

   // Extreme samples through a mute fade-out, then continuous silence while muted.
   task automatic test_mute();
      logic [47:0] e;
      int k0, fin;
      logic seen8;
      k0 = 0; fin = 1000; seen8 = 1'b0;
      src0_sample = {24'h7FFFFF, 24'h800000};
      mute = 1'b1;
      for (int c = 0; c < 45; c++) begin
         tick();
         if (c > fin) begin
            vectors++; if (s_r0 || s_r1 || !s_vld || !s_busy) begin miscompares++; $display("FAIL muted_state: rdy0 %b rdy1 %b valid %b busy %b want 0 0 1 1", s_r0, s_r1, s_vld, s_busy); end
         end
         if (s_xfer) begin
            vectors++;
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               if (s_dat !== e) begin miscompares++; $display("FAIL mute_frame: got %h want %h", s_dat, e); end
               if (e === {24'h7FFFFF, 24'h800000}) begin
                  vectors++; if (s_dat[47:24] !== 24'h7FFFFF) begin miscompares++; $display("FAIL gain_full_max: got %h want 7fffff", s_dat[47:24]); end
               end
               if (e === {24'h3FFFFF, 24'hC00000}) begin
                  seen8 = 1'b1;
                  vectors++; if (s_dat[23:0] !== 24'hC00000) begin miscompares++; $display("FAIL gain_half_min: got %h want c00000", s_dat[23:0]); end
               end
            end else if (k0 < 18) begin
               miscompares++; $display("FAIL mute_extra: got %h during fade, no frame expected", s_dat);
            end else if (s_dat !== 48'h0) begin
               miscompares++; $display("FAIL mute_silence: got %h want 0", s_dat);
            end
         end
         if (s_a0) begin
            exp_q.push_back(scale_frame(src0_sample, (k0 == 0) ? 16 : ((k0 <= 17) ? 17 - k0 : 0)));
            k0++;
            if (k0 == 18) fin = c;
         end
      end
      vectors++; if (!seen8 || k0 != 18) begin miscompares++; $display("FAIL mute_fade: g=8 frame seen %b, accepts %0d want 1, 18", seen8, k0); end
   endtask

   // Unmute into a src0 fade-in, then pulse reset once g has reached 7.
   task automatic test_reset_mid_fade();
      logic [47:0] e;
      int n0;
      n0 = 0;
      src0_sample = {24'h100000, 24'h100000};
      mute = 1'b0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (s_xfer) begin
            vectors++;
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               if (s_dat !== e) begin miscompares++; $display("FAIL unmute_frame: got %h want %h", s_dat, e); end
            end else if (n0 != 0 || s_dat !== 48'h0) begin
               miscompares++; $display("FAIL unmute_extra: got %h after %0d accepts", s_dat, n0);
            end
         end
         if (s_a0) begin
            exp_q.push_back(scale_frame(src0_sample, n0));
            n0++;
         end
         if (n0 == 7) break;
      end
      vectors++; if (n0 != 7) begin miscompares++; $display("FAIL mid_fade_timeout: accepts %0d want 7", n0); end
      #2 reset_n = 1'b0;
      #1;
      vectors++; if (audio_out !== 48'h0) begin miscompares++; $display("FAIL midreset_audio_out: got %h want 0", audio_out); end
      vectors++; if (audio_out_valid !== 1'b0) begin miscompares++; $display("FAIL midreset_valid: got %b want 0", audio_out_valid); end
      vectors++; if (src0_ready !== 1'b0 || src1_ready !== 1'b0) begin miscompares++; $display("FAIL midreset_ready: got %b %b want 0 0", src0_ready, src1_ready); end
      vectors++; if (busy !== 1'b1 || cur_sel !== 1'b0) begin miscompares++; $display("FAIL midreset_status: busy %b cur_sel %b want 1 0", busy, cur_sel); end
      exp_q.delete();
      @(negedge clk);
   endtask

   initial begin
      reset_n     = 1'b0;
      sel         = 1'b0;
      mute        = 1'b0;
      audio_full  = 1'b0;
      src0_valid  = 1'b1;
      src0_sample = {24'h100000, 24'h100000};
      src1_valid  = 1'b1;
      src1_sample = {24'(seq1 * 4096), 24'h100000};
      @(negedge clk);
      test_reset();
      test_fade_in();
      test_switch();
      test_stall();
      test_mute();
      test_reset_mid_fade();
      test_fade_in();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
